// File: rtl/gate_checker.sv
// Exercises a two-input gate block with all four input vectors and reports
// which gates responded incorrectly, how many vectors failed, and the first failure.
module gate_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       not_in,
    input  logic       nand_in,
    input  logic       nor_in,
    input  logic       xor_in,
    input  logic       xnor_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [6:0] err_mask,
    output logic [1:0] first_fail
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0] state;
    logic [1:0] idx;
    logic [3:0] settle_cnt;
    logic [6:0] expected;
    logic [6:0] observed;
    logic [6:0] mismatch;

    // Bit order matches err_mask: and, or, not, nand, nor, xor, xnor.
    always_comb begin
        expected = {~(a_out ^ b_out), a_out ^ b_out, ~(a_out | b_out),
                    ~(a_out & b_out), ~a_out, a_out | b_out, a_out & b_out};
        observed = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in};
        mismatch = expected ^ observed;
    end

    assign busy = (state == WAIT) || (state == CHECK);
    assign done = (state == DONE);

    // NOTE: every register below is assigned with <= so all updates in one
    // edge see the pre-edge values (e.g. err_count feeding first_fail capture).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            err_mask   <= 7'd0;
            first_fail <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pass       <= 1'b0;
                        err_count  <= 3'd0;
                        err_mask   <= 7'd0;
                        first_fail <= 2'd0;
                        idx        <= 2'd0;
                        {a_out, b_out} <= 2'b00;
                        settle_cnt <= 4'd0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_cnt == SETTLE_LAST) state <= CHECK;
                end
                CHECK: begin
                    if (mismatch != 7'd0) begin
                        err_count <= err_count + 3'd1;
                        err_mask  <= err_mask | mismatch;
                        // err_count is still zero only while no vector has failed yet.
                        if (err_count == 3'd0) first_fail <= {a_out, b_out};
                    end
                    if (idx == 2'd3) begin
                        state <= DONE;
                    end else begin
                        idx            <= idx + 2'd1;
                        {a_out, b_out} <= idx + 2'd1;
                        settle_cnt     <= 4'd0;
                        state          <= WAIT;
                    end
                end
                DONE: begin
                    pass  <= (err_count == 3'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
